lif_array_scheduler: RTL and testbench

- Time-multiplexes one shared leaky-integrate-and-fire update datapath across NUM_NEURONS virtual neurons.
- Membrane states and input currents are held in internal register arrays.
- On each `tick` the block sweeps all neurons in index order, one update per cycle.
- Spikes go out as `id` events over a valid/ready handshake. The block sits between the tile's input/config pins and the spike/state output pins.

---
 rtl/lif_array_scheduler_if.sv | 40 ++++
 rtl/lif_array_scheduler.sv | 133 +++++++++++++
 tb/tb_lif_array_scheduler.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lif_array_scheduler_if.sv
// ---------------------------------------------------------------------------
// lif_array_scheduler_if
// Groups the tile-facing signals of the LIF array scheduler into one bundle.
//   master : tile side; drives tick, current writes, threshold, spk_ready and
//            the debug read index; observes spikes, status and debug data.
//   slave  : the scheduler itself (mirror image of master).
// Signals:
//   tick, cur_we/cur_addr/cur_data, threshold      control and config inputs
//   spk_valid/spk_id/spk_ready                      spike event handshake
//   busy, done, overrun                             sweep status
//   st_rd_addr/st_rd_data                           debug membrane read port
// ---------------------------------------------------------------------------
interface lif_array_scheduler_if #(
   parameter int ID_W   = 2,
   parameter int DATA_W = 8
);
   logic              tick;
   logic              cur_we;
   logic [ID_W-1:0]   cur_addr;
   logic [DATA_W-1:0] cur_data;
   logic [DATA_W-1:0] threshold;
   logic              spk_valid;
   logic [ID_W-1:0]   spk_id;
   logic              spk_ready;
   logic              busy;
   logic              done;
   logic              overrun;
   logic [ID_W-1:0]   st_rd_addr;
   logic [DATA_W-1:0] st_rd_data;

   modport master (
      output tick, cur_we, cur_addr, cur_data, threshold, spk_ready, st_rd_addr,
      input  spk_valid, spk_id, busy, done, overrun, st_rd_data
   );

   modport slave (
      input  tick, cur_we, cur_addr, cur_data, threshold, spk_ready, st_rd_addr,
      output spk_valid, spk_id, busy, done, overrun, st_rd_data
   );
endinterface

// File: rtl/lif_array_scheduler.sv
// ---------------------------------------------------------------------------
// lif_array_scheduler
// Shares one leaky-integrate-and-fire update datapath across NUM_NEURONS
// virtual neurons. A tick starts a sweep that updates one neuron per cycle in
// index order; a neuron that reaches the threshold is reset to zero and its
// index is offered on the spike handshake before the sweep continues.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears all state and current regs)
//   bus    lif_array_scheduler_if.slave: tick, current write port, threshold,
//          spike valid/id/ready, busy/done/overrun status, debug state read
// ---------------------------------------------------------------------------
module lif_array_scheduler #(
   parameter int NUM_NEURONS = 4,
   parameter int ID_W        = 2,
   parameter int DATA_W      = 8,
   parameter int LEAK_SHIFT  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   lif_array_scheduler_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0] mem_q [NUM_NEURONS];
   logic [DATA_W-1:0] cur_q [NUM_NEURONS];
   logic              overrun_q;

   logic [DATA_W-1:0] v_leak;
   logic [DATA_W:0]   v_sum;
   logic [DATA_W-1:0] v_sat;
   logic              fire;
   logic              last;
   logic              upd_en;
   logic [DATA_W-1:0] upd_val;

   // Shared update datapath for the neuron under the index. The sum carries
   // one extra bit so an overflow can be clamped to all-ones.
   always_comb begin
      v_leak = mem_q[idx_q] >> LEAK_SHIFT;
      v_sum  = {1'b0, v_leak} + {1'b0, cur_q[idx_q]};
      v_sat  = v_sum[DATA_W] ? {DATA_W{1'b1}} : v_sum[DATA_W-1:0];
      fire   = (v_sat >= bus.threshold);
      last   = (idx_q == ID_W'(NUM_NEURONS - 1));
   end

   // Next-state logic. A neuron is written back only in SWEEP; EMIT stalls
   // the sweep with the index parked on the spiking neuron so spk_id is
   // simply the index register.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      upd_en  = 1'b0;
      upd_val = v_sat;
      case (state_q)
         IDLE: begin
            if (bus.tick) begin
               idx_d   = '0;
               state_d = SWEEP;
            end
         end
         SWEEP: begin
            upd_en = 1'b1;
            if (fire) begin
               upd_val = '0;
               state_d = EMIT;
            end else if (last) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + ID_W'(1);
            end
         end
         EMIT: begin
            if (bus.spk_ready) begin
               if (last) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + ID_W'(1);
                  state_d = SWEEP;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, membrane and current registers. Current writes land at the edge,
   // so an update in the same cycle still sees the previous current value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         overrun_q <= 1'b0;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            mem_q[i] <= '0;
            cur_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (upd_en) begin
            mem_q[idx_q] <= upd_val;
         end
         if (bus.cur_we) begin
            cur_q[bus.cur_addr] <= bus.cur_data;
         end
         if (bus.tick && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign bus.spk_valid  = (state_q == EMIT);
   assign bus.spk_id     = idx_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.overrun    = overrun_q;
   assign bus.st_rd_data = mem_q[bus.st_rd_addr];

endmodule

// File: tb/tb_lif_array_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lif_array_scheduler
// Directed self-checking bench for lif_array_scheduler. Expected spike ids
// are queued when a sweep is launched and popped by a monitor each time a
// spike handshake completes.
// ---------------------------------------------------------------------------
module tb_lif_array_scheduler;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   logic [1:0] sb [$];

   lif_array_scheduler_if #(.ID_W(2), .DATA_W(8)) ifc ();

   lif_array_scheduler #(
      .NUM_NEURONS(4),
      .ID_W(2),
      .DATA_W(8),
      .LEAK_SHIFT(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(ifc.slave)
   );

   // Free-running clock, 20 time units per cycle.
   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Pops the expected id for every completed spike handshake.
   always @(negedge clk) begin
      if (rst_n && ifc.spk_valid && ifc.spk_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL unexpected_spike: observed id %0d, expected no spike", ifc.spk_id);
         end else begin
            checkOutput("spk_id", 32'(ifc.spk_id), 32'(sb.pop_front()));
         end
      end
   end

   task automatic tickCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      #1;
      sb.delete();
      tickCycle();
      rst_n = 1'b1;
   endtask

   task automatic writeCur(input int a, input int d);
      ifc.cur_we   = 1'b1;
      ifc.cur_addr = 2'(a);
      ifc.cur_data = 8'(d);
      tickCycle();
      ifc.cur_we   = 1'b0;
   endtask

   task automatic checkState(input string tag, input int a, input int exp);
      ifc.st_rd_addr = 2'(a);
      #1;
      checkOutput(tag, 32'(ifc.st_rd_data), 32'(exp));
   endtask

   // Launches one sweep and checks the cycle (relative to the tick cycle) in
   // which done is seen; a missing done runs out the budget and mismatches.
   task automatic applyStimulus(input string tag, input int expCycles);
      int cycles;
      ifc.tick = 1'b1;
      tickCycle();
      ifc.tick = 1'b0;
      cycles = 1;
      while (!ifc.done && cycles < 100) begin
         tickCycle();
         cycles++;
      end
      checkOutput(tag, 32'(cycles), 32'(expCycles));
      tickCycle();
   endtask

   initial begin
      int cycles;
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      ifc.tick = 1'b0;
      ifc.cur_we = 1'b0;
      ifc.cur_addr = '0;
      ifc.cur_data = '0;
      ifc.threshold = 8'd100;
      ifc.spk_ready = 1'b0;
      ifc.st_rd_addr = '0;

      // Reset state, with a clock edge while reset is held.
      tickCycle();
      checkOutput("rst_spk_valid", 32'(ifc.spk_valid), 0);
      checkOutput("rst_spk_id", 32'(ifc.spk_id), 0);
      checkOutput("rst_busy", 32'(ifc.busy), 0);
      checkOutput("rst_done", 32'(ifc.done), 0);
      checkOutput("rst_overrun", 32'(ifc.overrun), 0);
      for (int i = 0; i < 4; i++) checkState("rst_state", i, 0);
      rst_n = 1'b1;
      repeat (3) tickCycle();
      checkOutput("idle_busy", 32'(ifc.busy), 0);
      checkOutput("idle_spk_valid", 32'(ifc.spk_valid), 0);
      for (int i = 0; i < 4; i++) checkState("idle_state", i, 0);

      // Plain sweep: busy for T+1..T+5, done only in T+5, no spikes.
      writeCur(0, 10);
      writeCur(1, 20);
      writeCur(2, 30);
      writeCur(3, 40);
      ifc.tick = 1'b1;
      checkOutput("plain_busy_T", 32'(ifc.busy), 0);
      for (int c = 1; c <= 6; c++) begin
         tickCycle();
         ifc.tick = 1'b0;
         checkOutput($sformatf("plain_busy_T+%0d", c), 32'(ifc.busy), (c <= 5) ? 1 : 0);
         checkOutput($sformatf("plain_done_T+%0d", c), 32'(ifc.done), (c == 5) ? 1 : 0);
         checkOutput($sformatf("plain_valid_T+%0d", c), 32'(ifc.spk_valid), 0);
      end
      checkState("plain_state0", 0, 10);
      checkState("plain_state1", 1, 20);
      checkState("plain_state2", 2, 30);
      checkState("plain_state3", 3, 40);

      // Integration: 60, 90, then 105 fires neuron 0.
      doReset();
      ifc.spk_ready = 1'b1;
      writeCur(0, 60);
      applyStimulus("integ_done1", 5);
      checkState("integ_state0_1", 0, 60);
      applyStimulus("integ_done2", 5);
      checkState("integ_state0_2", 0, 90);
      sb.push_back(2'd0);
      applyStimulus("integ_done3", 6);
      checkState("integ_state0_3", 0, 0);

      // Backpressure: spk_ready low for 5 cycles after spk_valid rises.
      doReset();
      ifc.spk_ready = 1'b1;
      writeCur(0, 60);
      writeCur(1, 5);
      applyStimulus("bp_done1", 5);
      applyStimulus("bp_done2", 5);
      checkState("bp_state1_pre", 1, 7);
      ifc.spk_ready = 1'b0;
      sb.push_back(2'd0);
      ifc.tick = 1'b1;
      tickCycle();
      ifc.tick = 1'b0;
      tickCycle();
      checkOutput("bp_valid_T+2", 32'(ifc.spk_valid), 1);
      checkOutput("bp_id_T+2", 32'(ifc.spk_id), 0);
      checkState("bp_state0_T+2", 0, 0);
      for (int c = 3; c <= 6; c++) begin
         tickCycle();
         checkOutput($sformatf("bp_valid_T+%0d", c), 32'(ifc.spk_valid), 1);
         checkOutput($sformatf("bp_id_T+%0d", c), 32'(ifc.spk_id), 0);
         checkState($sformatf("bp_state1_T+%0d", c), 1, 7);
      end
      tickCycle();
      ifc.spk_ready = 1'b1;
      checkOutput("bp_valid_T+7", 32'(ifc.spk_valid), 1);
      cycles = 7;
      while (!ifc.done && cycles < 100) begin
         tickCycle();
         cycles++;
      end
      checkOutput("bp_done_cycle", 32'(cycles), 11);
      checkState("bp_state1_post", 1, 8);
      tickCycle();

      // Saturation: 100 + 200 clamps to 255, which meets threshold 255.
      doReset();
      ifc.spk_ready = 1'b1;
      ifc.threshold = 8'd255;
      writeCur(2, 200);
      applyStimulus("sat_done1", 5);
      checkState("sat_state2_1", 2, 200);
      sb.push_back(2'd2);
      applyStimulus("sat_done2", 6);
      checkState("sat_state2_2", 2, 0);

      // Threshold zero: every neuron fires, in index order.
      doReset();
      ifc.spk_ready = 1'b1;
      ifc.threshold = 8'd0;
      for (int i = 0; i < 4; i++) sb.push_back(2'(i));
      applyStimulus("thr0_done", 9);
      checkOutput("thr0_sb_empty", 32'(sb.size()), 0);

      // Current writes during a sweep: same-cycle write uses the old value,
      // a write ahead of the index is picked up by this sweep.
      doReset();
      ifc.threshold = 8'd200;
      ifc.tick = 1'b1;
      tickCycle();
      ifc.tick = 1'b0;
      ifc.cur_we = 1'b1;
      ifc.cur_addr = 2'd0;
      ifc.cur_data = 8'd50;
      tickCycle();
      ifc.cur_addr = 2'd3;
      ifc.cur_data = 8'd7;
      tickCycle();
      ifc.cur_we = 1'b0;
      cycles = 3;
      while (!ifc.done && cycles < 100) begin
         tickCycle();
         cycles++;
      end
      checkOutput("wr_done_cycle", 32'(cycles), 5);
      checkState("wr_state0", 0, 0);
      checkState("wr_state3", 3, 7);
      tickCycle();

      // Abnormal control: tick during a sweep, then reset during EMIT.
      doReset();
      ifc.spk_ready = 1'b1;
      ifc.threshold = 8'd100;
      writeCur(0, 60);
      ifc.tick = 1'b1;
      tickCycle();
      ifc.tick = 1'b0;
      tickCycle();
      checkOutput("ab_overrun_pre", 32'(ifc.overrun), 0);
      ifc.tick = 1'b1;
      tickCycle();
      ifc.tick = 1'b0;
      checkOutput("ab_overrun_set", 32'(ifc.overrun), 1);
      cycles = 3;
      while (!ifc.done && cycles < 100) begin
         tickCycle();
         cycles++;
      end
      checkOutput("ab_done_cycle", 32'(cycles), 5);
      tickCycle();
      checkOutput("ab_busy_after", 32'(ifc.busy), 0);
      checkOutput("ab_overrun_sticky", 32'(ifc.overrun), 1);
      checkState("ab_state0", 0, 60);
      ifc.threshold = 8'd50;
      ifc.spk_ready = 1'b0;
      sb.push_back(2'd0);
      ifc.tick = 1'b1;
      tickCycle();
      ifc.tick = 1'b0;
      tickCycle();
      checkOutput("ab_emit_valid", 32'(ifc.spk_valid), 1);
      rst_n = 1'b0;
      #1;
      sb.delete();
      checkOutput("ab_rst_valid", 32'(ifc.spk_valid), 0);
      checkOutput("ab_rst_busy", 32'(ifc.busy), 0);
      checkOutput("ab_rst_overrun", 32'(ifc.overrun), 0);
      for (int i = 0; i < 4; i++) checkState("ab_rst_state", i, 0);
      tickCycle();
      rst_n = 1'b1;
      ifc.spk_ready = 1'b1;
      repeat (2) tickCycle();
      checkOutput("ab_post_valid", 32'(ifc.spk_valid), 0);
      checkOutput("final_sb_empty", 32'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
